// File: rtl/evo_truth_table_tester_pkg.sv
// Shared types and constants for the evolved-circuit truth-table tester.
package evo_test_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int DEF_IN_W          = 2;
    localparam int DEF_SETTLE_CYCLES = 16;
    localparam int DEF_SAMPLES       = 4;

    // Reflected binary Gray code: consecutive codes differ in exactly one bit.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 5'd1);
    endfunction

endpackage

// File: rtl/evo_truth_table_tester_if.sv
// Control/status bundle between the test sequencer and the truth-table tester.
interface evo_truth_table_tester_if #(
    parameter int IN_W = 2
);
    localparam int TBL_W = 1 << IN_W;

    logic             start;
    logic [TBL_W-1:0] expected;
    logic             busy;
    logic             done;
    logic [TBL_W-1:0] result;
    logic [TBL_W-1:0] unstable;
    logic             pass;

    modport master (
        output start, expected,
        input  busy, done, result, unstable, pass
    );

    modport slave (
        input  start, expected,
        output busy, done, result, unstable, pass
    );

endinterface

// File: rtl/evo_truth_table_tester_sync_2ff.sv
// Single-bit two-flop synchronizer for the asynchronous circuit-under-test output.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/evo_truth_table_tester.sv
// Steps an evolved circuit through all input vectors and records its truth table.
// Optional EVO_TESTER_GRAY_ORDER_EN walks the vectors in Gray order instead of binary.
module evo_truth_table_tester
    import evo_test_pkg::*;
#(
    parameter int IN_W          = DEF_IN_W,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int SAMPLES       = DEF_SAMPLES
) (
    input  logic                      clk,
    input  logic                      rst_n,
    evo_truth_table_tester_if.slave   ctrl,
    output logic [IN_W-1:0]           dut_in,
    input  logic                      dut_out
);

    localparam int TBL_W     = 1 << IN_W;
    localparam int STEP_W    = $clog2(TBL_W) + 1;
    localparam int LAST_STEP = TBL_W - 1;
    localparam int CNT_MAX   = (SETTLE_CYCLES > SAMPLES) ? SETTLE_CYCLES : SAMPLES;
    localparam int CNT_W     = $clog2(CNT_MAX) + 1;

    if (SETTLE_CYCLES < 3) begin : g_bad_settle
        $error("SETTLE_CYCLES must be at least 3 to cover synchronizer latency");
    end
    if (SAMPLES < 1) begin : g_bad_samples
        $error("SAMPLES must be at least 1");
    end

    state_t             state_r;
    logic [STEP_W-1:0]  step_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               busy_r;
    logic               done_r;
    logic               pass_r;
    logic [TBL_W-1:0]   result_r;
    logic [TBL_W-1:0]   unstable_r;
    logic [IN_W-1:0]    dut_in_r;

    logic               sample_s;
    logic [IN_W-1:0]    vec_s;
    logic               first_s;
    logic               later_miss_s;
    logic [TBL_W-1:0]   res_nxt_s;
    logic [TBL_W-1:0]   uns_nxt_s;
    logic               pass_nxt_s;

    // Map a step index to the input vector applied for it.
    function automatic logic [IN_W-1:0] vec_of(input logic [STEP_W-1:0] s);
`ifdef EVO_TESTER_GRAY_ORDER_EN
        return IN_W'(bin2gray(32'(s)));
`else
        return s[IN_W-1:0];
`endif
    endfunction

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (dut_out),
        .q     (sample_s)
    );

    assign vec_s        = vec_of(step_r);
    assign first_s      = (state_r == SAMPLE) && (cnt_r == CNT_W'(0));
    assign later_miss_s = (state_r == SAMPLE) && (cnt_r != CNT_W'(0)) &&
                          (sample_s != result_r[vec_s]);

    // Table contents after this cycle's sample, so pass can see the final sample.
    always_comb begin
        res_nxt_s = result_r;
        uns_nxt_s = unstable_r;
        if (first_s) begin
            res_nxt_s[vec_s] = sample_s;
        end else begin
            res_nxt_s[vec_s] = result_r[vec_s];
        end
        if (later_miss_s) begin
            uns_nxt_s[vec_s] = 1'b1;
        end else begin
            uns_nxt_s[vec_s] = unstable_r[vec_s];
        end
    end

    assign pass_nxt_s = (res_nxt_s == ctrl.expected) && (uns_nxt_s == TBL_W'(0));

    // Run sequencer: settle, sample, advance, report.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            step_r     <= STEP_W'(0);
            cnt_r      <= CNT_W'(0);
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            pass_r     <= 1'b0;
            result_r   <= TBL_W'(0);
            unstable_r <= TBL_W'(0);
            dut_in_r   <= IN_W'(0);
        end else begin
            case (state_r)
                IDLE: begin
                    done_r   <= 1'b0;
                    dut_in_r <= IN_W'(0);
                    if (ctrl.start) begin
                        result_r   <= TBL_W'(0);
                        unstable_r <= TBL_W'(0);
                        pass_r     <= 1'b0;
                        step_r     <= STEP_W'(0);
                        cnt_r      <= CNT_W'(0);
                        dut_in_r   <= vec_of(STEP_W'(0));
                        busy_r     <= 1'b1;
                        state_r    <= SETTLE;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (cnt_r == CNT_W'(SETTLE_CYCLES - 1)) begin
                        cnt_r   <= CNT_W'(0);
                        state_r <= SAMPLE;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                SAMPLE: begin
                    result_r   <= res_nxt_s;
                    unstable_r <= uns_nxt_s;
                    if (cnt_r == CNT_W'(SAMPLES - 1)) begin
                        cnt_r <= CNT_W'(0);
                        if (step_r == STEP_W'(LAST_STEP)) begin
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                            pass_r  <= pass_nxt_s;
                            state_r <= DONE;
                        end else begin
                            step_r   <= step_r + STEP_W'(1);
                            dut_in_r <= vec_of(step_r + STEP_W'(1));
                            state_r  <= SETTLE;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                DONE: begin
                    done_r   <= 1'b0;
                    dut_in_r <= IN_W'(0);
                    state_r  <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign dut_in        = dut_in_r;
    assign ctrl.busy     = busy_r;
    assign ctrl.done     = done_r;
    assign ctrl.pass     = pass_r;
    assign ctrl.result   = result_r;
    assign ctrl.unstable = unstable_r;

endmodule

// File: doc/evo_truth_table_tester.md
# evo_truth_table_tester

Test harness stage that drives the input vector of an evolved (LCELL-based, possibly asynchronous/feedback) circuit under test and captures its single-bit response. It steps through every input combination, holds each long enough for the circuit to settle, samples the output through a synchronizer several times to detect instability, and reports the measured truth table plus a pass/fail against an expected table. It sits directly upstream/downstream of the evolved circuit: `dut_in` feeds its input bus, `dut_out` consumes its output.

## Interface
- IN_W, 2, width of circuit-under-test input bus; table size is 2**IN_W entries
- SETTLE_CYCLES, 16, cycles each vector is held before sampling; must be >= 3 (elaboration error otherwise)
- SAMPLES, 4, consecutive output samples taken per vector; must be >= 1
- clk  in  1  sole clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a run; sampled only in IDLE
- expected  in  2**IN_W  expected truth table, bit k = expected output for input k
- dut_in  out  IN_W  drive to circuit-under-test input
- dut_out  in  1  circuit-under-test output, asynchronous to clk
- busy  out  1  high from cycle after accepted start until DONE
- done  out  1  one-cycle pulse, run complete
- result  out  2**IN_W  measured truth table, bit k = first sample for input k
- unstable  out  2**IN_W  bit k set if samples for input k disagreed
- pass  out  1  (result == expected) && (unstable == 0); updated with done, held

## Operation
- Reset values: dut_in=0, busy=0, done=0, result=0, unstable=0, pass=0, state IDLE, synchronizer flops 0.
- dut_out passes through a 2-flop synchronizer; all sampling uses its output.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: dut_in=0. start=1 → clear result, unstable, pass; step index=0; cnt=0; → SETTLE.
- SETTLE: dut_in=vec(step); cnt counts 0..SETTLE_CYCLES-1; at last count cnt=0, → SAMPLE.
- SAMPLE: one sample per cycle for SAMPLES cycles. Sample 0 writes result[vec]; any later sample differing from result[vec] sets unstable[vec] (sticky). After last sample: step==2**IN_W-1 → DONE, else step++ and → SETTLE.
- DONE: done=1 for this cycle, pass computed from final result/unstable/expected, busy=0; → IDLE.
- start while not IDLE ignored; start held high in IDLE restarts immediately after DONE.
- expected is sampled only in DONE; may change freely during a run.
- result/unstable/pass hold after done until next accepted start.
- Reset mid-run: immediate abort to reset values; no done pulse.
- Step counter width clog2(2**IN_W)+1 to avoid wrap on last compare; vec(step)=step in natural order.

## Timing
- start accepted on edge N → busy=1 and dut_in=vec(0) from edge N+1.
- Per vector: SETTLE_CYCLES + SAMPLES cycles.
- done asserted in cycle N+1+2**IN_W*(SETTLE_CYCLES+SAMPLES); defaults: N+81.
- Synchronizer latency 2 cycles is covered by SETTLE_CYCLES >= 3; sampled value reflects dut_out at least SETTLE_CYCLES-2 cycles after dut_in change.
- dut_in is registered; changes only on SETTLE entry.

## Configuration
- EVO_TESTER_GRAY_ORDER_EN defined: vec(step) = step ^ (step >> 1), so exactly one input bit toggles between consecutive vectors (limits hazards in feedback circuits); result/unstable still indexed by input value vec, not step.
- Undefined: vec(step)=step (binary order).

## Structure
- Package evo_test_pkg: state enum typedef (IDLE, SETTLE, SAMPLE, DONE), default constants for IN_W/SETTLE_CYCLES/SAMPLES, gray-conversion function.
- One sub-module: sync_2ff (1-bit two-flop synchronizer, clk/rst_n, reset value 0).

## Test plan
- AND-gate model on dut_out, expected=4'b1000, start pulse → done at start+81, result=4'b1000, unstable=0, pass=1.
- XOR model, expected=4'b1000 → result=4'b0110, pass=0, unstable=0.
- Model toggling dut_out every clk when dut_in==2'b11 → unstable=4'b1000, pass=0 regardless of expected.
- start asserted again at cycle 20 of run → ignored, single done at +81; reset asserted at cycle 40 → all outputs 0, no done.
- With EVO_TESTER_GRAY_ORDER_EN: dut_in sequence 00,01,11,10 each held 20 cycles; AND model still gives result=4'b1000.
- Model with 2-cycle output delay, SETTLE_CYCLES=3 → correct table, unstable=0.
